// File: rtl/miracle_midi_uart.sv
// rtl/miracle_midi_uart.sv - 31250-baud 8N1 MIDI UART for the Miracle Piano bridge.
// Define MIDI_THRU_EN to drive midi_thru from the synchronised receive line.
module miracle_midi_uart #(
    parameter int CLK_HZ = 21477000,
    parameter int BAUD   = 31250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_start,
    input  logic [15:0] tx_data,
    output logic        tx_busy,
    output logic [15:0] rx_data,
    output logic        rx_int,
    output logic        rx_ferr,
    output logic        midi_txd,
    input  logic        midi_rxd,
    output logic        midi_thru
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;

    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_int_q, rx_int_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic          sync1_q, sync2_q, prev_q;

    logic unused_tx_hi;
    assign unused_tx_hi = ^tx_data[15:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= T_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_int_q   <= 1'b0;
            rx_ferr_q  <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_int_q   <= rx_int_d;
            rx_ferr_q  <= rx_ferr_d;
            sync1_q    <= midi_rxd;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
        end
    end

    // Transmitter: start requests are only honoured from idle, so no queueing.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            T_IDLE: begin
                tx_cnt_d = '0;
                if (tx_start) begin
                    tx_state_d = T_START;
                    tx_shift_d = tx_data[7:0];
                end
            end
            T_START: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_state_d = T_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                end
            end
            T_DATA: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = T_STOP;
                end
            end
            default: begin
                if (tx_cnt_q == BIT_END) begin
                    tx_state_d = T_IDLE;
                    tx_cnt_d   = '0;
                end
            end
        endcase
    end

    // Receiver: a start edge is confirmed at mid-bit, then each bit is sampled at its centre.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_int_d   = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (prev_q && !sync2_q) rx_state_d = R_START;
            end
            R_START: begin
                if (rx_cnt_q == HALF_END) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = sync2_q ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
                end
            end
            R_STOP: begin
                if (rx_cnt_q == BIT_END) begin
                    rx_cnt_d = '0;
                    if (sync2_q) begin
                        rx_byte_d  = rx_shift_q;
                        rx_int_d   = 1'b1;
                        rx_state_d = R_IDLE;
                    end else begin
                        rx_ferr_d  = 1'b1;
                        rx_state_d = R_BREAK;
                    end
                end
            end
            default: begin
                rx_cnt_d = '0;
                if (sync2_q) rx_state_d = R_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_busy  = (tx_state_q != T_IDLE);
        midi_txd = 1'b1;
        if (tx_state_q == T_START) midi_txd = 1'b0;
        else if (tx_state_q == T_DATA) midi_txd = tx_shift_q[0];
        rx_data  = {8'h00, rx_byte_q};
        rx_int   = rx_int_q;
        rx_ferr  = rx_ferr_q;
    end

`ifdef MIDI_THRU_EN
    assign midi_thru = sync2_q;
`else
    assign midi_thru = 1'b1;
`endif

endmodule

// File: tb/tb_miracle_midi_uart.sv
// tb/tb_miracle_midi_uart.sv - self-checking bench for miracle_midi_uart.
module tb_miracle_midi_uart;
    localparam int DIV = 21477000 / 31250;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_start = 1'b0;
    logic [15:0] tx_data = 16'h0100;
    logic        midi_rxd = 1'b1;
    logic        tx_busy, rx_int, rx_ferr, midi_txd, midi_thru;
    logic [15:0] rx_data;

    int checks = 0;
    int errors = 0;
    int int_cnt = 0;
    int ferr_cnt = 0;
    int thru_err = 0;
    bit thru_chk = 1'b1;
    logic rxd_d1 = 1'b1;
    logic rxd_d2 = 1'b1;
    logic [15:0] exp_rx_data = 16'h0000;

    miracle_midi_uart dut (
        .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_int(rx_int), .rx_ferr(rx_ferr),
        .midi_txd(midi_txd), .midi_rxd(midi_rxd), .midi_thru(midi_thru)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rxd_d1 <= midi_rxd;
        rxd_d2 <= rxd_d1;
    end

    always @(negedge clk) begin
        if (rx_int === 1'b1) int_cnt++;
        if (rx_ferr === 1'b1) ferr_cnt++;
        if (thru_chk) begin
`ifdef MIDI_THRU_EN
            if (midi_thru !== rxd_d2) thru_err++;
`else
            if (midi_thru !== 1'b1) thru_err++;
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            midi_rxd = f[i];
            tick(DIV);
        end
    endtask

    task automatic rx_check(input string tag, input logic [7:0] b, input bit stop_ok);
        int i0, f0;
        i0 = int_cnt;
        f0 = ferr_cnt;
        rx_frame(b, stop_ok);
        if (!stop_ok) begin
            midi_rxd = 1'b1;
            tick(4);
        end
        if (stop_ok) exp_rx_data = {8'h00, b};
        chk({tag, " rx_int"}, int_cnt - i0, stop_ok ? 1 : 0);
        chk({tag, " rx_ferr"}, ferr_cnt - f0, stop_ok ? 0 : 1);
        chk({tag, " rx_data"}, {16'h0, rx_data}, {16'h0, exp_rx_data});
    endtask

    // Starts a frame on the current (idle) cycle; poke_at re-pulses tx_start at that busy index.
    task automatic run_tx(input string tag, input logic [7:0] b, input int poke_at);
        logic [9:0] f;
        int n, mism;
        f = {1'b1, b, 1'b0};
        n = 0;
        mism = 0;
        tx_data = {8'h01, b};
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_data = {8'h01, ~b};
        while (tx_busy === 1'b1 && n < 10 * DIV + 8) begin
            if (n >= 10 * DIV || midi_txd !== f[n / DIV]) mism++;
            n++;
            tx_start = (n == poke_at);
            @(negedge clk);
        end
        tx_start = 1'b0;
        chk({tag, " busy length"}, n, 10 * DIV);
        chk({tag, " bit errors"}, mism, 0);
    endtask

    initial begin
        int i0, f0;
        logic [7:0] tb, rb;
        bit ok;

        tick(4);
        reset = 1'b0;
        tick(1);
        chk("reset tx_busy", tx_busy, 0);
        chk("reset midi_txd", midi_txd, 1);
        chk("reset rx_int", rx_int, 0);
        chk("reset rx_ferr", rx_ferr, 0);
        chk("reset rx_data", rx_data, 16'h0000);
        chk("reset midi_thru", midi_thru, 1);

        run_tx("tx 0x90", 8'h90, -1);
        chk("tx idle line", midi_txd, 1);

        rx_check("rx 0x9C", 8'h9C, 1'b1);

        i0 = int_cnt;
        f0 = ferr_cnt;
        rx_frame(8'h55, 1'b0);
        tick(2000);
        chk("break rx_ferr", ferr_cnt - f0, 1);
        chk("break rx_int", int_cnt - i0, 0);
        chk("break rx_data", rx_data, exp_rx_data);
        midi_rxd = 1'b1;
        tick(DIV);
        rx_check("rx 0x3F", 8'h3F, 1'b1);

        i0 = int_cnt;
        f0 = ferr_cnt;
        midi_rxd = 1'b0;
        tick(100);
        midi_rxd = 1'b1;
        tick(DIV);
        chk("glitch rx_int", int_cnt - i0, 0);
        chk("glitch rx_ferr", ferr_cnt - f0, 0);

        run_tx("tx poke mid", 8'hC3, 3000);
        run_tx("tx back2back", 8'h5A, 10 * DIV);
        tick(3);
        chk("start on last busy cycle ignored", tx_busy, 0);
        chk("line idle after ignore", midi_txd, 1);

        tx_data = 16'h01A7;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        for (int i = 0; i < 3700; i++) begin
            midi_rxd = (i < 1000);
            tick(1);
        end
        chk("busy before reset", tx_busy, 1);
        thru_chk = 1'b0;
        i0 = int_cnt;
        f0 = ferr_cnt;
        reset = 1'b1;
        midi_rxd = 1'b1;
        tick(1);
        reset = 1'b0;
        exp_rx_data = 16'h0000;
        chk("abort midi_txd", midi_txd, 1);
        chk("abort tx_busy", tx_busy, 0);
        chk("abort rx_int", rx_int, 0);
        tick(4);
        thru_chk = 1'b1;
        tick(DIV);
        chk("abort no rx_int", int_cnt - i0, 0);
        chk("abort no rx_ferr", ferr_cnt - f0, 0);
        chk("abort tx stays idle", tx_busy, 0);
        chk("abort rx_data", rx_data, 16'h0000);
        fork
            run_tx("roundtrip tx 0xF0", 8'hF0, -1);
            rx_check("roundtrip rx 0xF0", 8'hF0, 1'b1);
        join

        for (int k = 0; k < 3; k++) begin
            tb = 8'($urandom);
            rb = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            fork
                run_tx("random tx", tb, -1);
                rx_check("random rx", rb, ok);
            join
        end

        chk("midi_thru mismatches", thru_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
